// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and framing constants for the UART receive path
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_HALF_BIT   = UART_OVERSAMPLE / 2 - 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    // Tick index that lands in the middle of a bit when counting from a detected edge.
    function automatic int half_bit(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-side word delivery bundle between uart_rx and its consumer
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_busy,
        input frame_err
    );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with a selectable reset level
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1 UART receiver with mid-bit sampling and framing-error flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_en,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(half_bit(OVERSAMPLE));
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_e          state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ferr_q, ferr_nxt;
    logic                 busy;
    logic                 rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= bit_nxt;
            shreg    <= shreg_nxt;
            data_q   <= data_nxt;
            valid_q  <= valid_nxt;
            ferr_q   <= ferr_nxt;
        end
    end

    // Everything holds between ticks; the strobes default low so they last one clk.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        if (rx_en) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    tick_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_HALF) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    tick_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_LAST) begin
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_nxt   = bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            state_nxt = STOP;
                            tick_nxt  = '0;
                        end
                    end
                end
                STOP: begin
                    tick_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_LAST) begin
                        if (rx_s) begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy;
    assign bus.frame_err = ferr_q;

endmodule
